uart_rx_frame_store: RTL and testbench

Serial receive stage of the UART device. It takes the raw `rx` pin and produces one stored frame word per received UART frame. It samples each bit at mid-bit using the runtime bit period `clkdiv`, checks start and stop bits, and writes each frame into a small circular frame memory. The memory feeds the receive-page display path; the last data byte drives the receive LEDs.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_framer.sv | 144 ++++++++++++++
 rtl/uart_rx_frame_store.sv | 106 ++++++++++
 tb/tb_uart_rx_frame_store.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, minimum bit period and
// frame-word field offsets used by the receive, transmit and display paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned MIN_CLKDIV = 4;

    // Frame word layout: {ferr, stop, data[DATA_BIT-1:0], start}
    localparam int unsigned START_POS = 0;
    localparam int unsigned DATA_LSB  = 1;

    function automatic int unsigned stop_pos(input int unsigned data_bit);
        return DATA_LSB + data_bit;
    endfunction

    function automatic int unsigned ferr_pos(input int unsigned data_bit);
        return DATA_LSB + data_bit + 1;
    endfunction

    function automatic int unsigned frame_width(input int unsigned data_bit);
        return data_bit + 3;
    endfunction

endpackage

// File: rtl/uart_rx_framer.sv
// UART receive framer: input synchronizer, start-edge detect, mid-bit sampling
// of data and stop bits. Emits a one-cycle frame_valid pulse with the data
// byte and the sampled stop bit.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_clkdiv         : bit period in clocks (latched at start edge, min 4)
//   i_rx             : asynchronous serial line, idle high
//   o_frame_valid    : one-cycle pulse, frame complete
//   o_data, o_stop   : data byte and stop bit of that frame
//   o_busy           : FSM not idle
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BIT    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [15:0]         i_clkdiv,
    input  logic                i_rx,
    output logic                o_frame_valid,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_stop,
    output logic                o_busy
);

    localparam int unsigned IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    rx_state_t              r_state;
    logic [15:0]            r_per;
    logic [15:0]            r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_BIT-1:0]    r_shift;
    logic                   r_valid;
    logic [DATA_BIT-1:0]    r_data;
    logic                   r_stop;
    logic                   r_busy;

    logic                   w_rx_s;
    logic [15:0]            w_half;
    logic [15:0]            w_per_lat;
    rx_state_t              w_state_nxt;
    logic [15:0]            w_per_nxt;
    logic [15:0]            w_cnt_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [DATA_BIT-1:0]    w_shift_nxt;
    logic                   w_valid_nxt;
    logic [DATA_BIT-1:0]    w_data_nxt;
    logic                   w_stop_nxt;

    assign w_rx_s    = r_sync[SYNC_STAGES-1];
    assign w_half    = r_per >> 1;
    assign w_per_lat = (i_clkdiv < 16'(MIN_CLKDIV)) ? 16'(MIN_CLKDIV) : i_clkdiv;

    // State register, synchronizer and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
            r_state   <= IDLE;
            r_per     <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_stop    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_sync[0] <= i_rx;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_rx_prev <= w_rx_s;
            r_state   <= w_state_nxt;
            r_per     <= w_per_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_valid   <= w_valid_nxt;
            r_data    <= w_data_nxt;
            r_stop    <= w_stop_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    // Next state: r_cnt counts cycles since the last sample point (or detect)
    always_comb begin
        w_state_nxt = r_state;
        w_per_nxt   = r_per;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_valid_nxt = 1'b0;
        w_data_nxt  = r_data;
        w_stop_nxt  = r_stop;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = 16'd1;
                if (!w_rx_s && r_rx_prev) begin
                    w_per_nxt   = w_per_lat;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_cnt == w_half) begin
                    w_cnt_nxt   = 16'd1;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == r_per) begin
                    w_cnt_nxt          = 16'd1;
                    w_shift_nxt[r_idx] = w_rx_s;
                    if (r_idx == IDX_W'(DATA_BIT - 1)) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                // Stay in STOP through the commit cycle so a new start is
                // only accepted the cycle after the frame is stored.
                if (r_valid) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == r_per) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = r_shift;
                    w_stop_nxt  = w_rx_s;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_frame_valid = r_valid;
    assign o_data        = r_data;
    assign o_stop        = r_stop;
    assign o_busy        = r_busy;

endmodule

// File: rtl/uart_rx_frame_store.sv
// UART receive stage with circular frame memory.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_clkdiv       : bit period in clocks (min 4, latched per frame)
//   i_rx           : asynchronous serial input, idle high
//   o_rx_data      : data byte of the last completed frame
//   o_rx_done      : one-cycle pulse per completed frame
//   o_frame_err    : last frame had a low stop bit (sticky to next frame)
//   o_busy         : receiver not idle
//   o_wr_ptr       : next memory index to write
//   o_frame_count  : valid entries, saturating at ITEM_COUNT
//   o_frame_mem    : frame words {ferr, stop, data, start}
module uart_rx_frame_store
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BIT    = 8,
    parameter int unsigned ITEM_COUNT  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic [15:0]                               i_clkdiv,
    input  logic                                      i_rx,
    output logic [DATA_BIT-1:0]                       o_rx_data,
    output logic                                      o_rx_done,
    output logic                                      o_frame_err,
    output logic                                      o_busy,
    output logic [$clog2(ITEM_COUNT)-1:0]             o_wr_ptr,
    output logic [$clog2(ITEM_COUNT):0]               o_frame_count,
    output logic [ITEM_COUNT-1:0][DATA_BIT+2:0]       o_frame_mem
);

    localparam int unsigned PTR_W    = $clog2(ITEM_COUNT);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned FW       = frame_width(DATA_BIT);
    localparam int unsigned STOP_BIT = stop_pos(DATA_BIT);
    localparam int unsigned FERR_BIT = ferr_pos(DATA_BIT);

    logic                           w_fr_valid;
    logic [DATA_BIT-1:0]            w_fr_data;
    logic                           w_fr_stop;
    logic                           w_busy;
    logic [FW-1:0]                  w_word;

    logic [ITEM_COUNT-1:0][FW-1:0]  r_mem;
    logic [PTR_W-1:0]               r_wr_ptr;
    logic [CNT_W-1:0]               r_count;
    logic [DATA_BIT-1:0]            r_rx_data;
    logic                           r_rx_done;
    logic                           r_frame_err;

    uart_rx_framer #(
        .DATA_BIT    (DATA_BIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_framer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clkdiv      (i_clkdiv),
        .i_rx          (i_rx),
        .o_frame_valid (w_fr_valid),
        .o_data        (w_fr_data),
        .o_stop        (w_fr_stop),
        .o_busy        (w_busy)
    );

    // Frame word assembly
    always_comb begin
        w_word            = '0;
        w_word[START_POS] = 1'b0;
        w_word[DATA_LSB +: DATA_BIT] = w_fr_data;
        w_word[STOP_BIT]  = w_fr_stop;
        w_word[FERR_BIT]  = ~w_fr_stop;
    end

    // Commit: when full, the entry at wr_ptr is the oldest and is overwritten
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem       <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_rx_data   <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            if (w_fr_valid) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                if (r_count != CNT_W'(ITEM_COUNT)) begin
                    r_count <= r_count + CNT_W'(1);
                end
                r_rx_data   <= w_fr_data;
                r_frame_err <= ~w_fr_stop;
                r_rx_done   <= 1'b1;
            end
        end
    end

    assign o_rx_data     = r_rx_data;
    assign o_rx_done     = r_rx_done;
    assign o_frame_err   = r_frame_err;
    assign o_busy        = w_busy;
    assign o_wr_ptr      = r_wr_ptr;
    assign o_frame_count = r_count;
    assign o_frame_mem   = r_mem;

endmodule

// File: tb/tb_uart_rx_frame_store.sv
// Scoreboard bench for uart_rx_frame_store: expected frames are queued as
// they are sent and checked when rx_done fires.
module tb_uart_rx_frame_store;

    localparam int unsigned DATA_BIT    = 8;
    localparam int unsigned ITEM_COUNT  = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FW          = DATA_BIT + 3;

    logic                             clk = 1'b0;
    logic                             rst = 1'b1;
    logic [15:0]                      clkdiv = 16'd868;
    logic                             rx = 1'b1;
    logic [DATA_BIT-1:0]              rx_data;
    logic                             rx_done;
    logic                             frame_err;
    logic                             busy;
    logic [1:0]                       wr_ptr;
    logic [2:0]                       frame_count;
    logic [ITEM_COUNT-1:0][FW-1:0]    frame_mem;

    uart_rx_frame_store #(
        .DATA_BIT    (DATA_BIT),
        .ITEM_COUNT  (ITEM_COUNT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_clkdiv      (clkdiv),
        .i_rx          (rx),
        .o_rx_data     (rx_data),
        .o_rx_done     (rx_done),
        .o_frame_err   (frame_err),
        .o_busy        (busy),
        .o_wr_ptr      (wr_ptr),
        .o_frame_count (frame_count),
        .o_frame_mem   (frame_mem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         idx;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   m_ptr = 0;
    int   m_cnt = 0;
    int   total = 0;
    int   bad   = 0;
    int   n_done = 0;
    int   done_cyc = 0;
    int   tx_start_cyc = 0;
    bit   abort_tx = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void expect_frame(input logic [7:0] d, input logic ferr);
        exp_t e;
        m_cnt = (m_cnt < int'(ITEM_COUNT)) ? m_cnt + 1 : m_cnt;
        e.data = d;
        e.ferr = ferr;
        e.idx  = m_ptr;
        e.cnt  = m_cnt;
        exp_q.push_back(e);
        m_ptr = (m_ptr + 1) % int'(ITEM_COUNT);
    endfunction

    // Drive one frame, LSB first; tail_low keeps the line low after a low stop bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input int per, input int tail_low);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        @(posedge clk); #1;
        tx_start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int c = 0; c < per; c++) begin
                @(posedge clk); #1;
                if (abort_tx) begin
                    rx = 1'b1;
                    return;
                end
            end
        end
        for (int c = 0; c < tail_low; c++) begin
            @(posedge clk); #1;
        end
        rx = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check_eq({tag, "_rx_done"}, 32'(rx_done), 32'd0);
        check_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_wr_ptr"}, 32'(wr_ptr), 32'd0);
        check_eq({tag, "_count"}, 32'(frame_count), 32'd0);
        for (int i = 0; i < int'(ITEM_COUNT); i++) begin
            check_eq({tag, "_mem"}, 32'(frame_mem[i]), 32'd0);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (rx_done) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", 32'(rx_done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                done_cyc = cyc;
                n_done++;
                check_eq("rx_data", 32'(rx_data), 32'(mon_e.data));
                check_eq("frame_err", 32'(frame_err), 32'(mon_e.ferr));
                check_eq("mem_word", 32'(frame_mem[mon_e.idx]),
                         32'({mon_e.ferr, ~mon_e.ferr, mon_e.data, 1'b0}));
                check_eq("wr_ptr", 32'(wr_ptr), 32'((mon_e.idx + 1) % int'(ITEM_COUNT)));
                check_eq("frame_count", 32'(frame_count), 32'(mon_e.cnt));
            end
        end
    end

    logic [ITEM_COUNT-1:0][FW-1:0] snap;
    logic [7:0] wrap_exp [4];
    int done_before;

    initial begin
        wrap_exp = '{8'h14, 8'h15, 8'h12, 8'h13};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        // Single frame at 868, latency from pin edge to visible rx_done
        clkdiv = 16'd868;
        expect_frame(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1, 868, 0);
        wait_idle(2000);
        check_eq("latency_868", 32'(done_cyc - tx_start_cyc),
                 32'(SYNC_STAGES + 1 + 434 + (DATA_BIT + 1) * 868 + 1));
        check_eq("single_mem0", 32'(frame_mem[0]), 32'h34A);
        check_eq("single_ptr", 32'(wr_ptr), 32'd1);
        check_eq("single_cnt", 32'(frame_count), 32'd1);

        // Glitch: 200 low cycles, start rejected at mid-bit
        snap = frame_mem;
        done_before = n_done;
        @(posedge clk); #1;
        rx = 1'b0;
        for (int c = 1; c <= 436; c++) begin
            @(posedge clk); #1;
            if (c == 200) rx = 1'b1;
        end
        check_eq("glitch_busy_hold", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check_eq("glitch_busy_drop", 32'(busy), 32'd0);
        repeat (50) @(posedge clk);
        #1;
        for (int i = 0; i < int'(ITEM_COUNT); i++) begin
            check_eq("glitch_mem", 32'(frame_mem[i]), 32'(snap[i]));
        end
        check_eq("glitch_no_done", 32'(n_done), 32'(done_before));

        // Framing error with line held low afterwards, then a good frame
        clkdiv = 16'd32;
        expect_frame(8'h3C, 1'b1);
        send_frame(8'h3C, 1'b0, 32, 100);
        wait_idle(500);
        check_eq("ferr_sticky", 32'(frame_err), 32'd1);
        check_eq("ferr_bit10", 32'(frame_mem[1][10]), 32'd1);
        expect_frame(8'h01, 1'b0);
        send_frame(8'h01, 1'b1, 32, 0);
        wait_idle(500);
        check_eq("ferr_cleared", 32'(frame_err), 32'd0);

        // Wrap-around from a clean memory
        pulse_reset();
        clkdiv = 16'd16;
        for (int i = 0; i < 6; i++) begin
            expect_frame(8'(8'h10 + i), 1'b0);
            send_frame(8'(8'h10 + i), 1'b1, 16, 0);
        end
        wait_idle(500);
        check_eq("wrap_cnt", 32'(frame_count), 32'd4);
        check_eq("wrap_ptr", 32'(wr_ptr), 32'd2);
        for (int i = 0; i < int'(ITEM_COUNT); i++) begin
            check_eq("wrap_data", 32'(frame_mem[i][8:1]), 32'(wrap_exp[i]));
        end

        // Reset during bit 4 of 0x77
        clkdiv = 16'd64;
        fork
            send_frame(8'h77, 1'b1, 64, 0);
            begin
                repeat (4 * 64 + 32) @(posedge clk);
                #1;
                check_eq("midrst_busy", 32'(busy), 32'd1);
                abort_tx = 1'b1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_reset_state("midrst");
            end
        join
        abort_tx = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        exp_q.delete();
        repeat (200) @(posedge clk);
        #1;
        check_eq("midrst_idle", 32'(busy), 32'd0);
        check_eq("midrst_cnt", 32'(frame_count), 32'd0);
        expect_frame(8'h55, 1'b0);
        send_frame(8'h55, 1'b1, 64, 0);
        wait_idle(500);

        // clkdiv below minimum acts as 4
        clkdiv = 16'd2;
        expect_frame(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b1, 4, 0);
        wait_idle(200);
        check_eq("latency_min", 32'(done_cyc - tx_start_cyc),
                 32'(SYNC_STAGES + 1 + 2 + (DATA_BIT + 1) * 4 + 1));

        // clkdiv changed mid-frame, then a frame at the new rate
        clkdiv = 16'd868;
        expect_frame(8'hC3, 1'b0);
        fork
            send_frame(8'hC3, 1'b1, 868, 0);
            begin
                repeat (3000) @(posedge clk);
                #1;
                clkdiv = 16'd434;
            end
        join
        expect_frame(8'h96, 1'b0);
        send_frame(8'h96, 1'b1, 434, 0);
        wait_idle(2000);
        check_eq("latency_434", 32'(done_cyc - tx_start_cyc),
                 32'(SYNC_STAGES + 1 + 217 + (DATA_BIT + 1) * 434 + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case something wedges
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
